// File: rtl/shift_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle shift sequencer.
package shift_pkg;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle for shift_sequencer.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_op, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_op, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift step; bits shifted out are dropped.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        unique case (op)
            SH_PASS: q = d;
            SH_LSL:  q = {d[WIDTH-2:0], 1'b0};
            SH_LSR:  q = {1'b0, d[WIDTH-1:1]};
            SH_ASR:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit step per clock between two valid/ready handshakes.
// Define SHIFT_SEQ_BYPASS_EN to send zero-amount and pass ops straight to DONE.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] step_q;
    logic             in_ready, out_valid, busy;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op (op_q),
        .d  (data_q),
        .q  (step_q)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_d    = data_q;
        op_d      = op_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    op_d    = bus.in_op;
                    count_d = bus.in_amt;
`ifdef SHIFT_SEQ_BYPASS_EN
                    if (bus.in_amt == '0 || bus.in_op == SH_PASS) begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
`else
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    data_d  = step_q;
                    count_d = count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            data_q  <= '0;
            op_q    <= SH_PASS;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            op_q    <= op_d;
        end
    end

    // Data register doubles as the result; it only moves in IDLE/SHIFT.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected result and latency queued on accept.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_sequencer #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_data(input logic [1:0] op,
                                                    input logic [WIDTH-1:0] d,
                                                    input logic [AMT_W-1:0] amt);
        logic signed [WIDTH-1:0] s;
        s = d;
        case (op)
            SH_LSL:  return d << amt;
            SH_LSR:  return d >> amt;
            SH_ASR:  return s >>> amt;
            default: return d;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [AMT_W-1:0] amt);
`ifdef SHIFT_SEQ_BYPASS_EN
        if (amt == 0 || op == SH_PASS) return 0;
`endif
        if (amt == 0) return 1;
        return int'(amt);
    endfunction

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d,
                        input logic [AMT_W-1:0] amt);
        int w;
        exp_t e;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("send_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_amt   = amt;
        e.data = model_data(op, d, amt);
        e.lat  = model_lat(op, amt);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        int   lat;
        exp_t e;
        logic [WIDTH-1:0] seen;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_data"}, 32'(bus.out_data), 32'(e.data));
        check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        seen = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            // Competing request while the result is stalled must be refused.
            bus.in_valid = 1'b1;
            bus.in_op    = SH_LSL;
            bus.in_data  = ~seen;
            bus.in_amt   = 4'd1;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(bus.out_data), 32'(e.data));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_ret_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ret_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ret_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]       r_op;
        logic [WIDTH-1:0] r_d;
        logic [AMT_W-1:0] r_amt;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;

        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send(SH_LSL, 16'h0001, 4'd4);
        collect("t1_lsl4", 0);

        send(SH_ASR, 16'h8000, 4'd15);
        collect("t2_asr15", 0);
        send(SH_LSR, 16'h8000, 4'd15);
        collect("t2_lsr15", 0);

        send(SH_LSL, 16'hA5A5, 4'd0);
        collect("t3_amt0", 0);

        send(SH_LSR, 16'h1234, 4'd2);
        collect("t4_stall", 5);

        send(SH_LSL, 16'h0003, 4'd10);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(SH_LSL, 16'h0003, 4'd10);
        collect("t5_after_rst", 0);

        send(SH_LSR, 16'h0F00, 4'd3);
        collect("t6_lsr3", 0);
        send(SH_ASR, 16'hF000, 4'd2);
        collect("t6_asr2", 0);

        send(SH_PASS, 16'h5A5A, 4'd6);
        collect("pass6", 0);

        for (int i = 0; i < 12; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_d   = 16'($urandom);
            r_amt = 4'($urandom_range(0, 15));
            send(r_op, r_d, r_amt);
            collect("rand", $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
